// File: rtl/tlb_op_ctrl.sv
// Sequencer for the TLBP/TLBR/TLBWI/TLBWR maintenance instructions between CP0 and the MMU.
// It also owns the CP0 Random register, which TLBWR uses to pick its victim entry.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    output logic             op_ready,
    output logic             op_done,
    input  logic             flush,
    input  logic [31:0]      cp0_entry_hi,
    input  logic [31:0]      cp0_entry_lo0,
    input  logic [31:0]      cp0_entry_lo1,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_wired,
    input  logic             wired_we,
    output logic [31:0]      random,
    output logic [IDX_W-1:0] tlbrw_index,
    output logic             tlbrw_we,
    output logic [77:0]      tlbrw_wdata,
    input  logic [77:0]      tlbrw_rdata,
    output logic [31:0]      tlbp_entry_hi,
    input  logic [31:0]      tlbp_index,
    output logic             wb_index_we,
    output logic [31:0]      wb_index,
    output logic             wb_entry_we,
    output logic [31:0]      wb_entry_hi,
    output logic [31:0]      wb_entry_lo0,
    output logic [31:0]      wb_entry_lo1,
    output logic             tlb_changed
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CAPTURE, S_WRITE, S_DONE} state_t;

    localparam logic [1:0]       OP_TLBP  = 2'd0;
    localparam logic [1:0]       OP_TLBR  = 2'd1;
    localparam logic [1:0]       OP_TLBWR = 2'd3;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TLB_ENTRIES - 1);

    state_t           r_state, w_next;
    logic [1:0]       r_op;
    logic [31:0]      r_hi;
    logic [25:0]      r_lo0, r_lo1;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_random, w_random_next;
    logic [77:0]      r_rdata;
    logic [31:0]      r_probe;
    logic             w_accept;
    logic             w_is_read;
    logic             w_unused;

    assign op_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept  = op_valid && op_ready && !flush;
    assign w_is_read = (op_type == OP_TLBP) || (op_type == OP_TLBR);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    always_comb begin
        w_next      = r_state;
        op_done     = 1'b0;
        tlbrw_we    = 1'b0;
        wb_index_we = 1'b0;
        wb_entry_we = 1'b0;
        tlb_changed = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = w_is_read ? S_LOOKUP : S_WRITE;
            S_LOOKUP:  w_next = flush ? S_IDLE : S_CAPTURE;
            S_CAPTURE: w_next = flush ? S_IDLE : S_DONE;
            S_WRITE: begin
                tlbrw_we = !flush && !reset;
                w_next   = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                op_done     = 1'b1;
                wb_index_we = (r_op == OP_TLBP);
                wb_entry_we = (r_op == OP_TLBR);
                tlb_changed = r_op[1];
                w_next      = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Operands are frozen at accept; TLBWR takes its victim from Random as it stood then.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= '0;
            r_hi  <= '0;
            r_lo0 <= '0;
            r_lo1 <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_op  <= op_type;
            r_hi  <= cp0_entry_hi;
            r_lo0 <= cp0_entry_lo0[25:0];
            r_lo1 <= cp0_entry_lo1[25:0];
            r_idx <= (op_type == OP_TLBWR) ? r_random : cp0_index[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_probe <= '0;
        end else if (r_state == S_CAPTURE && !flush) begin
            if (r_op == OP_TLBP) r_probe <= tlbp_index;
            else                 r_rdata <= tlbrw_rdata;
        end
    end

    always_comb begin
        w_random_next = r_random - IDX_W'(1);
        if (wired_we || cp0_wired >= 32'(TLB_ENTRIES) || random == cp0_wired)
            w_random_next = IDX_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset) r_random <= IDX_MAX;
        else       r_random <= w_random_next;
    end

    assign random        = 32'(r_random);
    assign tlbrw_index   = r_idx;
    assign tlbp_entry_hi = r_hi;
    assign tlbrw_wdata   = {r_hi[31:13], r_hi[7:0], r_lo0[0] & r_lo1[0], r_lo0[25:1], r_lo1[25:1]};

    // Only one G bit is stored, so it is replicated into both EntryLo writebacks.
    assign wb_index      = r_probe;
    assign wb_entry_hi   = {r_rdata[77:59], 5'b0, r_rdata[58:51]};
    assign wb_entry_lo0  = {6'b0, r_rdata[49:25], r_rdata[50]};
    assign wb_entry_lo1  = {6'b0, r_rdata[24:0], r_rdata[50]};

    assign w_unused = &{1'b0, cp0_index, cp0_entry_lo0[31:26], cp0_entry_lo1[31:26]};
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: the driver predicts MMU writes and CP0 writebacks per op,
// a negedge monitor plays the MMU, checks Random every cycle and pops expectations on strobes.
module tb_tlb_op_ctrl;
    localparam int N  = 16;
    localparam int IW = $clog2(N);
    localparam logic [1:0] TLBP = 2'd0, TLBR = 2'd1, TLBWI = 2'd2, TLBWR = 2'd3;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef enum int {EV_WRITE, EV_WB_INDEX, EV_WB_ENTRY, EV_CHANGED} ev_kind_t;
    typedef struct {
        int          cyc;
        ev_kind_t    kind;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [77:0] wdata;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid, flush, wired_we;
    logic [1:0]    op_type;
    logic [31:0]   cp0_entry_hi, cp0_entry_lo0, cp0_entry_lo1, cp0_index, cp0_wired;
    logic [77:0]   tlbrw_rdata;
    logic [31:0]   tlbp_index;
    logic          op_ready, op_done, tlbrw_we, wb_index_we, wb_entry_we, tlb_changed;
    logic [31:0]   random, tlbp_entry_hi, wb_index, wb_entry_hi, wb_entry_lo0, wb_entry_lo1;
    logic [IW-1:0] tlbrw_index;
    logic [77:0]   tlbrw_wdata;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     rnd_model = 0;
    bit     armed = 1'b0;
    entry_t tlb [N];
    ev_t    exp_q [$];

    tlb_op_ctrl #(.TLB_ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .op_done(op_done), .flush(flush), .cp0_entry_hi(cp0_entry_hi), .cp0_entry_lo0(cp0_entry_lo0),
        .cp0_entry_lo1(cp0_entry_lo1), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
        .wired_we(wired_we), .random(random), .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
        .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi),
        .tlbp_index(tlbp_index), .wb_index_we(wb_index_we), .wb_index(wb_index),
        .wb_entry_we(wb_entry_we), .wb_entry_hi(wb_entry_hi), .wb_entry_lo0(wb_entry_lo0),
        .wb_entry_lo1(wb_entry_lo1), .tlb_changed(tlb_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic miss(input string name, input string detail);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    function automatic entry_t make_entry(input logic [31:0] hi, input logic [31:0] lo0,
                                          input logic [31:0] lo1);
        entry_t e;
        e.vpn2 = hi[31:13];
        e.asid = hi[7:0];
        e.g    = lo0[0] & lo1[0];
        e.pfn0 = lo0[25:6];
        e.c0   = lo0[5:3];
        e.d0   = lo0[2];
        e.v0   = lo0[1];
        e.pfn1 = lo1[25:6];
        e.c1   = lo1[5:3];
        e.d1   = lo1[2];
        e.v1   = lo1[1];
        return e;
    endfunction

    // First matching entry wins; a global entry ignores the ASID.
    function automatic logic [31:0] probe(input logic [31:0] hi);
        for (int i = 0; i < N; i++)
            if (tlb[i].vpn2 == hi[31:13] && (tlb[i].g || tlb[i].asid == hi[7:0])) return 32'(i);
        return 32'h8000_0000;
    endfunction

    function automatic logic [4:0] strobes_of(input ev_kind_t k);
        case (k)
            EV_WRITE:    return 5'b10000;
            EV_WB_INDEX: return 5'b01100;
            EV_WB_ENTRY: return 5'b01010;
            default:     return 5'b01001;
        endcase
    endfunction

    task automatic push(input int c, input ev_kind_t k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic [31:0] f, input logic [77:0] w);
        ev_t e;
        e.cyc = c; e.kind = k; e.d0 = a; e.d1 = b; e.d2 = d; e.d3 = f; e.wdata = w;
        exp_q.push_back(e);
    endtask

    // Monitor: MMU responder, Random model and scoreboard consumer.
    initial begin
        logic [4:0]    st;
        ev_t           e;
        logic [IW-1:0] prev_idx;
        logic [31:0]   prev_hi, last_idx, last_hi, last_lo0, last_lo1;
        prev_idx = '0; prev_hi = '0;
        last_idx = '0; last_hi = '0; last_lo0 = '0; last_lo1 = '0;
        tlbrw_rdata = '0;
        tlbp_index  = '0;
        forever begin
            @(negedge clk);
            tlbrw_rdata = tlb[prev_idx];
            tlbp_index  = probe(prev_hi);
            prev_idx    = tlbrw_index;
            prev_hi     = tlbp_entry_hi;
            if (armed) begin
                check("random", random, 80'(rnd_model));
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    miss("missing_event", $sformatf("got no strobe, want event kind %0d at cycle %0d",
                                                    exp_q[0].kind, exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
                st = {tlbrw_we, op_done, wb_index_we, wb_entry_we, tlb_changed};
                if (st != 5'b0) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        miss("unexpected_strobe", $sformatf("got strobes %b, want 00000", st));
                    end else begin
                        e = exp_q.pop_front();
                        check("strobes", st, strobes_of(e.kind));
                        case (e.kind)
                            EV_WRITE: begin
                                check("tlbrw_index", tlbrw_index, e.d0);
                                check("tlbrw_wdata", tlbrw_wdata, e.wdata);
                            end
                            EV_WB_INDEX: begin
                                check("wb_index", wb_index, e.d0);
                                last_idx = e.d0;
                            end
                            EV_WB_ENTRY: begin
                                check("wb_entry_hi", wb_entry_hi, e.d1);
                                check("wb_entry_lo0", wb_entry_lo0, e.d2);
                                check("wb_entry_lo1", wb_entry_lo1, e.d3);
                                last_hi = e.d1; last_lo0 = e.d2; last_lo1 = e.d3;
                            end
                            default: ;
                        endcase
                    end
                end
                if (!wb_index_we) check("wb_index_hold", wb_index, last_idx);
                if (!wb_entry_we) begin
                    check("wb_hi_hold", wb_entry_hi, last_hi);
                    check("wb_lo0_hold", wb_entry_lo0, last_lo0);
                    check("wb_lo1_hold", wb_entry_lo1, last_lo1);
                end
            end
            if (reset || wired_we || cp0_wired >= 32'(N) || cp0_wired == 32'(rnd_model))
                rnd_model = N - 1;
            else
                rnd_model = (rnd_model + N - 1) % N;
            if (reset) begin
                armed = 1'b1;
                last_idx = '0; last_hi = '0; last_lo0 = '0; last_lo1 = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_wired(input logic [31:0] v);
        cp0_wired = v;
        wired_we  = 1'b1;
        step();
        wired_we  = 1'b0;
    endtask

    // fl_at: cycle offset after accept carrying flush (0 = the accept cycle itself, -1 = none).
    task automatic run_op(input logic [1:0] t, input int fl_at, input bit rst_in_wr,
                          input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                          input logic [31:0] idx_reg);
        int            a, lat, stop;
        bit            kill;
        logic [IW-1:0] tidx;
        entry_t        e;
        flush = 1'b0;
        cp0_entry_hi = hi; cp0_entry_lo0 = lo0; cp0_entry_lo1 = lo1; cp0_index = idx_reg;
        op_type = t; op_valid = 1'b1;
        if (fl_at == 0) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            #1;
            check("flush_blocks_accept", op_ready, 1);
        end
        a    = cyc;
        tidx = (t == TLBWR) ? IW'(rnd_model) : idx_reg[IW-1:0];
        lat  = (t == TLBP || t == TLBR) ? 3 : 2;
        kill = (fl_at >= 1 && fl_at < lat) || rst_in_wr;
        stop = rst_in_wr ? 1 : (kill ? fl_at : lat);
        if (!kill) begin
            case (t)
                TLBP: push(a + 3, EV_WB_INDEX, probe(hi), 0, 0, 0, '0);
                TLBR: begin
                    e = tlb[tidx];
                    push(a + 3, EV_WB_ENTRY, 0, {e.vpn2, 5'b0, e.asid},
                         {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g},
                         {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g}, '0);
                end
                default: begin
                    e = make_entry(hi, lo0, lo1);
                    push(a + 1, EV_WRITE, 32'(tidx), 0, 0, 0, e);
                    push(a + 2, EV_CHANGED, 0, 0, 0, 0, '0);
                    tlb[tidx] = e;
                end
            endcase
        end
        for (int k = 1; k <= stop + 1; k++) begin
            step();
            flush = (k == fl_at);
            reset = rst_in_wr && (k == 1);
            cp0_entry_hi = $urandom; cp0_entry_lo0 = $urandom;
            cp0_entry_lo1 = $urandom; cp0_index = $urandom;
            op_valid = (k <= stop) ? 1'($urandom) : 1'b0;
            op_type  = 2'($urandom);
            #1;
            if (k == 1)        check("busy_not_ready", op_ready, 0);
            if (k == stop + 1) check("ready_after_op", op_ready, 1);
        end
        flush = 1'b0;
    endtask

    initial begin
        bit found;
        int t, fl;
        reset = 1'b1; op_valid = 1'b0; op_type = '0; flush = 1'b0; wired_we = 1'b0;
        cp0_entry_hi = '0; cp0_entry_lo0 = '0; cp0_entry_lo1 = '0; cp0_index = '0; cp0_wired = 32'd3;
        for (int i = 0; i < N; i++) begin
            tlb[i] = '0;
            tlb[i].vpn2 = 19'(i + 'h100);
            tlb[i].asid = 8'(i);
        end
        repeat (3) begin
            step();
            check("reset_ready", op_ready, 0);
            check("reset_we", tlbrw_we, 0);
        end
        reset = 1'b0;
        #1;
        check("post_reset_ready", op_ready, 1);
        check("post_reset_random", random, 15);
        check("post_reset_wdata", tlbrw_wdata, 0);
        check("post_reset_probe_key", tlbp_entry_hi, 0);
        check("post_reset_done", op_done, 0);

        // Random sweep with wired=3, then rewrite Wired mid-sweep, then an out-of-range Wired.
        repeat (20) step();
        pulse_wired(32'd10);
        repeat (12) step();
        pulse_wired(32'd20);
        repeat (5) step();
        pulse_wired(32'd3);

        run_op(TLBWI, -1, 0, 32'h0040_2003, 32'h0000_1047, 32'h0000_1087, 32'd5);
        run_op(TLBR, -1, 0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF5);
        run_op(TLBP, -1, 0, 32'hFFFF_E0FF, 32'h0, 32'h0, 32'h0);
        run_op(TLBP, -1, 0, 32'h0020_E007, 32'h0, 32'h0, 32'h0);
        run_op(TLBP, -1, 0, 32'h0040_2077, 32'h0, 32'h0, 32'h0);

        // TLBWR accepted while Random is 9 must write entry 9.
        pulse_wired(32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (rnd_model == 9) found = 1'b1;
        end
        if (!found) miss("random_reach_9", "got no cycle with random 9, want one within 40 cycles");
        else run_op(TLBWR, -1, 0, 32'hABCD_E012, 32'h03FF_FFFF, 32'h0000_0043, 32'h0);

        run_op(TLBR, 2, 0, 32'h0, 32'h0, 32'h0, 32'd9);
        run_op(TLBR, 1, 0, 32'h0, 32'h0, 32'h0, 32'd9);
        run_op(TLBP, 0, 0, 32'hABCD_E012, 32'h0, 32'h0, 32'h0);
        run_op(TLBR, 3, 0, 32'h0, 32'h0, 32'h0, 32'd9);
        run_op(TLBWI, 1, 0, 32'h1111_1111, 32'h2222_2223, 32'h3333_3333, 32'd2);
        run_op(TLBWI, 2, 0, 32'h4444_4444, 32'h0555_5555, 32'h0666_6667, 32'd3);
        run_op(TLBWI, -1, 1, 32'h7777_7777, 32'h0888_8889, 32'h0999_9999, 32'd4);
        run_op(TLBR, -1, 0, 32'h0, 32'h0, 32'h0, 32'd2);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] hi;
            int          k;
            t  = $urandom_range(0, 3);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (t >= 2) ? 2 : 3) : -1;
            hi = $urandom;
            if (t == 0 && $urandom_range(0, 1) == 1) begin
                k  = $urandom_range(0, N - 1);
                hi = {tlb[k].vpn2, 5'($urandom), tlb[k].asid};
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pulse_wired(32'd0);
                    1:       pulse_wired(32'd5);
                    2:       pulse_wired(32'd15);
                    default: pulse_wired(32'd20);
                endcase
            end
            run_op(2'(t), fl, (t >= 2) && ($urandom_range(0, 11) == 0), hi, $urandom, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (6) step();
        while (exp_q.size() > 0) begin
            miss("leftover_event", $sformatf("got nothing, want event kind %0d at cycle %0d",
                                             exp_q[0].kind, exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
